// File: rtl/fft_pkg.sv
// fft_pkg: shared constants and helpers for the MDC FFT datapath.
//   WIDTH_DEF              default real/imag sample width
//   RND_CONST / RND_SHIFT  round-half-up constant 2^(WIDTH-3) and shift WIDTH-2
//   SAT_MAX / SAT_MIN      signed WIDTH-bit limits used when saturating
// The rnd_*/sat_* functions give the same quantities for any sample width,
// so parameterised blocks stay consistent with the default constants.
package fft_pkg;

  localparam int WIDTH_DEF = 10;

  function automatic int rnd_shift(input int w);
    return w - 32'sd2;
  endfunction

  function automatic int rnd_const(input int w);
    return 32'sd1 << (w - 32'sd3);
  endfunction

  function automatic int sat_max(input int w);
    return (32'sd1 << (w - 32'sd1)) - 32'sd1;
  endfunction

  function automatic int sat_min(input int w);
    return -(32'sd1 << (w - 32'sd1));
  endfunction

  localparam int RND_SHIFT = rnd_shift(WIDTH_DEF);
  localparam int RND_CONST = rnd_const(WIDTH_DEF);
  localparam int SAT_MAX   = sat_max(WIDTH_DEF);
  localparam int SAT_MIN   = sat_min(WIDTH_DEF);

endpackage

// File: rtl/fft_delay_line.sv
// fft_delay_line: DEPTH-entry shift register that advances only when en=1.
//   clk, rst_n  clock, asynchronous active-low reset (clears every entry)
//   en          shift enable (one accepted sample)
//   din         word entering the line
//   dout        word that entered DEPTH enabled cycles ago
module fft_delay_line #(
  parameter int WIDTH2 = 20,
  parameter int DEPTH  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [WIDTH2-1:0] din,
  output logic [WIDTH2-1:0] dout
);

  logic [WIDTH2-1:0] mem_r [DEPTH];

  // Shift register storage, advanced once per enabled cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {WIDTH2{1'b0}};
      end
    end else if (en) begin
      mem_r[0] <= din;
      for (int i = 1; i < DEPTH; i++) begin
        mem_r[i] <= mem_r[i-1];
      end
    end
  end

  assign dout = mem_r[DEPTH-1];

endmodule

// File: rtl/fft_mdc_commutator.sv
// fft_mdc_commutator: rescale lane B back to WIDTH bits, then perform the MDC
// delay-switch-delay reorder so the next butterfly sees pairs DEPTH apart.
//   clk, rst_n        clock, asynchronous active-low reset
//   sync              frame restart: clears sample counter and priming
//   in_valid          lane A/B sample present
//   a_re, a_im        lane A sample (WIDTH, signed)
//   b_re, b_im        lane B product (2*WIDTH-1, signed)
//   b_bypass          1: lane B is an unscaled sample, take its low WIDTH bits
//   y0_re, y0_im      later element of the output pair (registered)
//   y1_re, y1_im      earlier element, DEPTH samples before y0 (registered)
//   out_valid         output pair valid (registered)
// Build option: COMMUTATOR_SAT_EN clamps out-of-range rounded products to the
// signed WIDTH-bit limits; without it they wrap to the low WIDTH bits.
module fft_mdc_commutator
  import fft_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   sync,
  input  logic                   in_valid,
  input  logic signed [WIDTH-1:0]   a_re,
  input  logic signed [WIDTH-1:0]   a_im,
  input  logic signed [2*WIDTH-2:0] b_re,
  input  logic signed [2*WIDTH-2:0] b_im,
  input  logic                   b_bypass,
  output logic signed [WIDTH-1:0] y0_re,
  output logic signed [WIDTH-1:0] y0_im,
  output logic signed [WIDTH-1:0] y1_re,
  output logic signed [WIDTH-1:0] y1_im,
  output logic                   out_valid
);

  localparam int BW = 2*WIDTH - 1;
  localparam int SW = 2*WIDTH;            // one guard bit for the rounding add
  localparam int SB = $clog2(DEPTH);      // counter bit that drives the switch
  localparam int CW = SB + 1;             // counter counts mod 2*DEPTH
  localparam int SHIFT = rnd_shift(WIDTH);
  localparam logic signed [SW-1:0] RCONST = SW'(rnd_const(WIDTH));
`ifdef COMMUTATOR_SAT_EN
  localparam logic signed [SW-1:0] MAXV = SW'(sat_max(WIDTH));
  localparam logic signed [SW-1:0] MINV = SW'(sat_min(WIDTH));
`endif

  // Round-half-up then reduce to WIDTH bits; bypassed samples pass untouched.
  function automatic logic [WIDTH-1:0] rescale(input logic [BW-1:0] b,
                                               input logic       byp);
    logic signed [SW-1:0] sum;
    logic signed [SW-1:0] sh;
    logic        [WIDTH-1:0] r;
    sum = $signed({b[BW-1], b}) + RCONST;
    sh  = sum >>> SHIFT;
    if (byp) begin
      r = b[WIDTH-1:0];
    end else begin
`ifdef COMMUTATOR_SAT_EN
      if (sh > MAXV) begin
        r = MAXV[WIDTH-1:0];
      end else if (sh < MINV) begin
        r = MINV[WIDTH-1:0];
      end else begin
        r = sh[WIDTH-1:0];
      end
`else
      r = sh[WIDTH-1:0];
`endif
    end
    return r;
  endfunction

  logic [CW-1:0]      cnt_r;
  logic               primed_r;
  logic [CW-1:0]      cnt_s;
  logic               primed_s;
  logic               sw_s;
  logic [WIDTH-1:0]   rb_re_s, rb_im_s;
  logic [2*WIDTH-1:0] da_s;
  logic [2*WIDTH-1:0] m0_s, m1_s;
  logic [2*WIDTH-1:0] d2_s;

  // sync restarts the frame in the same cycle, so a sample accepted with it is k=0.
  always_comb begin
    cnt_s    = sync ? {CW{1'b0}} : cnt_r;
    primed_s = sync ? 1'b0 : primed_r;
    sw_s     = cnt_s[SB];
    rb_re_s  = rescale(b_re, b_bypass);
    rb_im_s  = rescale(b_im, b_bypass);
  end

  fft_delay_line #(.WIDTH2(2*WIDTH), .DEPTH(DEPTH)) u_dl1 (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (in_valid),
    .din   ({a_re, a_im}),
    .dout  (da_s)
  );

  // Switch: route delayed A and current B to the two branches.
  always_comb begin
    if (sw_s) begin
      m0_s = {rb_re_s, rb_im_s};
      m1_s = da_s;
    end else begin
      m0_s = da_s;
      m1_s = {rb_re_s, rb_im_s};
    end
  end

  fft_delay_line #(.WIDTH2(2*WIDTH), .DEPTH(DEPTH)) u_dl2 (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (in_valid),
    .din   (m1_s),
    .dout  (d2_s)
  );

  // Sample counter, sticky priming flag and the registered output pair.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r     <= {CW{1'b0}};
      primed_r  <= 1'b0;
      y0_re     <= {WIDTH{1'b0}};
      y0_im     <= {WIDTH{1'b0}};
      y1_re     <= {WIDTH{1'b0}};
      y1_im     <= {WIDTH{1'b0}};
      out_valid <= 1'b0;
    end else if (in_valid) begin
      cnt_r     <= cnt_s + CW'(1);
      // The sample after k=DEPTH-1 is the first with a full pair behind it.
      primed_r  <= primed_s | (cnt_s == CW'(DEPTH - 1));
      y0_re     <= m0_s[2*WIDTH-1:WIDTH];
      y0_im     <= m0_s[WIDTH-1:0];
      y1_re     <= d2_s[2*WIDTH-1:WIDTH];
      y1_im     <= d2_s[WIDTH-1:0];
      out_valid <= primed_s;
    end else begin
      cnt_r     <= cnt_s;
      primed_r  <= primed_s;
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fft_mdc_commutator.sv
// tb_fft_mdc_commutator: directed bench for fft_mdc_commutator (WIDTH=10,
// DEPTH=2). A sample-indexed model computes expected outputs from the switch
// and delay rules; literal tables pin the model on known streams.
module tb_fft_mdc_commutator;

  localparam int W = 10;
  localparam int D = 2;

  logic clk = 1'b0;
  logic rst_n, sync, in_valid, b_bypass;
  logic signed [W-1:0]   a_re, a_im;
  logic signed [2*W-2:0] b_re, b_im;
  logic signed [W-1:0]   y0_re, y0_im, y1_re, y1_im;
  logic out_valid;

  fft_mdc_commutator #(.WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n), .sync(sync), .in_valid(in_valid),
    .a_re(a_re), .a_im(a_im), .b_re(b_re), .b_im(b_im), .b_bypass(b_bypass),
    .y0_re(y0_re), .y0_im(y0_im), .y1_re(y1_re), .y1_im(y1_im),
    .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_on = 0;

`ifdef COMMUTATOR_SAT_EN
  localparam int BIG_R = 511;
`else
  localparam int BIG_R = -6;
`endif

  // model state, indexed by absolute sample number since reset
  int hn, kc;
  int ah_re[512], ah_im[512], m1h_re[512], m1h_im[512];
  int e_y0_re, e_y0_im, e_y1_re, e_y1_im;
  bit e_valid;
  int log_y0[$], log_y1[$];

  int tab_y0[6] = '{202, 203, 102, 103, 206, 207};
  int tab_y1[6] = '{200, 201, 100, 101, 204, 205};
  int sync_pat[8] = '{0, 0, 1, 0, 0, 1, 1, 1};

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int wrap_w(input int v);
    int r;
    r = v & 1023;
    if (r >= 512) r = r - 1024;
    return r;
  endfunction

  function automatic int resc(input int b, input bit byp);
    int r;
    if (byp) return wrap_w(b);
    r = (b + 128) >>> 8;
`ifdef COMMUTATOR_SAT_EN
    if (r > 511) r = 511;
    if (r < -512) r = -512;
`else
    r = wrap_w(r);
`endif
    return r;
  endfunction

  task automatic model_reset();
    hn = 0; kc = 0;
    e_y0_re = 0; e_y0_im = 0; e_y1_re = 0; e_y1_im = 0;
    e_valid = 0;
  endtask

  task automatic model_step(input bit iv, input bit sy, input int ar, input int ai,
                            input int br, input int bi, input bit byp);
    int rb_re, rb_im, da_re, da_im;
    bit s;
    if (sy) kc = 0;
    if (!iv) begin
      e_valid = 0;
      return;
    end
    rb_re = resc(br, byp);
    rb_im = resc(bi, byp);
    da_re = (hn >= D) ? ah_re[hn-D] : 0;
    da_im = (hn >= D) ? ah_im[hn-D] : 0;
    s = (kc % (2*D)) >= D;
    e_y0_re = s ? rb_re : da_re;
    e_y0_im = s ? rb_im : da_im;
    m1h_re[hn] = s ? da_re : rb_re;
    m1h_im[hn] = s ? da_im : rb_im;
    e_y1_re = (hn >= D) ? m1h_re[hn-D] : 0;
    e_y1_im = (hn >= D) ? m1h_im[hn-D] : 0;
    ah_re[hn] = ar;
    ah_im[hn] = ai;
    e_valid = (kc >= D);
    kc++;
    hn++;
  endtask

  // drive at the negedge, update the model at the posedge, return at the negedge
  task automatic step(input bit iv, input bit sy, input int ar, input int ai,
                      input int br, input int bi, input bit byp);
    in_valid = iv; sync = sy; b_bypass = byp;
    a_re = ar[W-1:0]; a_im = ai[W-1:0];
    b_re = br[2*W-2:0]; b_im = bi[2*W-2:0];
    @(posedge clk);
    model_step(iv, sy, ar, ai, br, bi, byp);
    @(negedge clk);
  endtask

  task automatic do_reset();
    #2;
    rst_n = 0;
    in_valid = 0; sync = 0;
    model_reset();
    #1;
    chk("rst_y0_re", y0_re, 0);
    chk("rst_y1_re", y1_re, 0);
    chk("rst_y0_im", y0_im, 0);
    chk("rst_valid", out_valid, 0);
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic run_stream(input bit gap);
    for (int k = 0; k < 8; k++) begin
      step(1, 0, 100 + k, -(100 + k), 200 + k, -(200 + k), 1);
      if (gap) step(0, 0, 0, 0, 0, 0, 0);
    end
  endtask

  task automatic check_pairs(input string nm);
    chk({nm, "_count"}, log_y0.size(), 6);
    for (int i = 0; i < 6 && i < log_y0.size(); i++) begin
      chk({nm, "_y0"}, log_y0[i], tab_y0[i]);
      chk({nm, "_y1"}, log_y1[i], tab_y1[i]);
    end
  endtask

  // compare DUT outputs against the model on every cycle
  always @(negedge clk) begin
    if (chk_on) begin
      chk("out_valid", out_valid, e_valid);
      chk("y0_re", y0_re, e_y0_re);
      chk("y0_im", y0_im, e_y0_im);
      chk("y1_re", y1_re, e_y1_re);
      chk("y1_im", y1_im, e_y1_im);
      if (out_valid) begin
        log_y0.push_back(y0_re);
        log_y1.push_back(y1_re);
      end
    end
  end

  initial begin
    rst_n = 0; sync = 0; in_valid = 0; b_bypass = 0;
    a_re = '0; a_im = '0; b_re = '0; b_im = '0;
    model_reset();
    #12;
    chk("init_y0_re", y0_re, 0);
    chk("init_y1_im", y1_im, 0);
    chk("init_valid", out_valid, 0);
    @(negedge clk);
    rst_n = 1;
    chk_on = 1;

    // rescale: product samples land at k mod 4 in {2,3}, seen on y0 directly
    step(1, 0, 0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 25600, -384, 0);
    chk("rs_25600", y0_re, 100);
    chk("rs_im_m384", y0_im, -1);
    step(1, 0, 0, 0, 384, 260610, 0);
    chk("rs_384", y0_re, 2);
    chk("rs_im_260610", y0_im, BIG_R);
    step(1, 0, 0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0, 0, 1);
    step(1, 0, 0, 0, -384, 0, 0);
    chk("rs_m384", y0_re, -1);
    step(1, 0, 0, 0, 260610, 0, 0);
    chk("rs_260610", y0_re, BIG_R);
    step(1, 0, 0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0, 0, 1);
    step(1, 0, 0, 0, -5, -5, 1);
    chk("rs_bypass_m5", y0_re, -5);
    chk("rs_bypass_m5_im", y0_im, -5);
    step(0, 0, 0, 0, 0, 0, 0);

    // back-to-back stream
    do_reset();
    log_y0.delete(); log_y1.delete();
    run_stream(0);
    step(0, 0, 0, 0, 0, 0, 0);
    check_pairs("b2b");

    // same stream with idle cycles between samples
    do_reset();
    log_y0.delete(); log_y1.delete();
    run_stream(1);
    step(0, 0, 0, 0, 0, 0, 0);
    check_pairs("gap");

    // reset mid-frame after k=5, then restart
    do_reset();
    for (int k = 0; k < 6; k++) begin
      step(1, 0, 100 + k, -(100 + k), 200 + k, -(200 + k), 1);
    end
    do_reset();
    log_y0.delete(); log_y1.delete();
    run_stream(0);
    step(0, 0, 0, 0, 0, 0, 0);
    check_pairs("rst_restart");

    // sync with in_valid on the fourth sample
    do_reset();
    for (int i = 0; i < 8; i++) begin
      step(1, (i == 3), 100 + i, -(100 + i), 200 + i, -(200 + i), 1);
      chk("sync_valid", out_valid, sync_pat[i]);
    end
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);

    chk_on = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
